pool_window_scheduler: RTL and testbench

Sequencer in front of the 2x2 max-pooling unit. It accepts one output-feature-map channel in raster order from the PE array/GLB drain path and buffers one even row in a line buffer. On each odd row it emits 2x2 windows to the pooling unit as four consecutive enabled elements. It also counts pooled results returning from the unit and signals completion of the map.

---
 rtl/pool_window_scheduler_pkg.sv | 23 ++
 rtl/pool_line_buffer.sv | 31 +++
 rtl/pool_window_scheduler.sv | 248 ++++++++++++++++++++++++
 tb/tb_pool_window_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_window_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package    : pool_pkg
// Description: Shared types and defaults for the 2x2 pooling window scheduler.
// Revision   : 1.0 - initial release
// ============================================================================
package pool_pkg;

    localparam int POOL_DATA_W    = 8;
    localparam int POOL_MAX_WIDTH = 64;
    localparam int WINDOW_ELEMS   = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROW_EVEN = 3'd1,
        ROW_ODD  = 3'd2,
        EMIT     = 3'd3,
        SKIP_ROW = 3'd4,
        DRAIN    = 3'd5
    } pool_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/pool_line_buffer.sv
`default_nettype none
// ============================================================================
// Module     : pool_line_buffer
// Description: One-row line buffer, synchronous write, column-addressed read.
// Revision   : 1.0 - initial release
// ============================================================================
module pool_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/pool_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : pool_window_scheduler
// Description: Buffers even rows and streams 2x2 windows to the max-pool unit.
//              Optional stall counter enabled by macro POOL_SCHED_PERF_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module pool_window_scheduler
    import pool_pkg::*;
#(
    parameter int DATA_W    = POOL_DATA_W,
    parameter int MAX_WIDTH = POOL_MAX_WIDTH,
    parameter int DIM_W     = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              pool_clear,
    output logic              pool_enable,
    output logic [DATA_W-1:0] pool_data,
    output logic              pool_data_valid,
    input  logic              pool_result_valid,
    output logic              busy,
    output logic              done,
    output logic [31:0]       perf_stall_cycles
);

    localparam int                AW        = $clog2(MAX_WIDTH);
    localparam int                CW        = 2 * DIM_W;
    localparam logic [DIM_W-1:0]  DIM_ONE   = DIM_W'(1);
    localparam logic [DIM_W-1:0]  DIM_TWO   = DIM_W'(2);
    localparam logic [DIM_W-1:0]  DIM_MAX   = DIM_W'(MAX_WIDTH);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [1:0]        EMIT_LAST = 2'(WINDOW_ELEMS - 1);

    pool_sched_state_t r_state;
    pool_sched_state_t w_row_done_state;

    logic [DIM_W-1:0]  r_width;
    logic [DIM_W-1:0]  r_height;
    logic [DIM_W-1:0]  r_col;
    logic [DIM_W-1:0]  r_row_pair;
    logic [1:0]        r_emit_idx;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] r_pool_data;
    logic [CW-1:0]     r_result_cnt;
    logic [CW-1:0]     r_total;
    logic              r_busy;
    logic              r_done;
    logic              r_pool_clear;
    logic              r_pool_enable;

    logic              w_xfer;
    logic              w_wr_en;
    logic              w_last_col;
    logic              w_last_pair;
    logic              w_cfg_legal;
    logic [AW-1:0]     w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic [CW-1:0]     w_cnt_next;

    assign in_ready        = (r_state == ROW_EVEN) || (r_state == ROW_ODD) || (r_state == SKIP_ROW);
    assign w_xfer          = in_valid & in_ready;
    assign w_wr_en         = w_xfer && (r_state == ROW_EVEN);
    assign w_last_col      = (r_col == (r_width - DIM_ONE));
    assign w_last_pair     = (r_row_pair == ((r_height >> 1) - DIM_ONE));
    assign w_cfg_legal     = (cfg_width >= DIM_TWO) && (cfg_width <= DIM_MAX) && (cfg_height >= DIM_TWO);
    assign w_cnt_next      = (r_busy && pool_result_valid) ? (r_result_cnt + CNT_ONE) : r_result_cnt;
    // Entering EMIT fetches the left column of the pair; inside EMIT the right one.
    assign w_rd_addr       = (r_state == EMIT) ? r_col[AW-1:0] : AW'(r_col - DIM_ONE);

    assign pool_clear      = r_pool_clear;
    assign pool_enable     = r_pool_enable;
    assign pool_data_valid = r_pool_enable;
    assign pool_data       = r_pool_data;
    assign busy            = r_busy;
    assign done            = r_done;

    always_comb begin
        w_row_done_state = DRAIN;
        if (!w_last_pair) begin
            w_row_done_state = ROW_EVEN;
        end else if (r_height[0]) begin
            w_row_done_state = SKIP_ROW;
        end
    end

    pool_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_WIDTH),
        .ADDR_W (AW)
    ) u_line_buf (
        .clock   (clock),
        .wr_en   (w_wr_en),
        .wr_addr (r_col[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_width       <= '0;
            r_height      <= '0;
            r_col         <= '0;
            r_row_pair    <= '0;
            r_emit_idx    <= '0;
            r_hold        <= '0;
            r_cur         <= '0;
            r_pool_data   <= '0;
            r_result_cnt  <= '0;
            r_total       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pool_clear  <= 1'b0;
            r_pool_enable <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_pool_clear <= 1'b0;
            r_result_cnt <= w_cnt_next;

            case (r_state)
                IDLE: begin
                    if (cfg_start) begin
                        r_width      <= cfg_width;
                        r_height     <= cfg_height;
                        r_col        <= '0;
                        r_row_pair   <= '0;
                        r_emit_idx   <= '0;
                        r_result_cnt <= '0;
                        r_total      <= CW'(cfg_width >> 1) * CW'(cfg_height >> 1);
                        if (w_cfg_legal) begin
                            r_busy       <= 1'b1;
                            r_pool_clear <= 1'b1;
                            r_state      <= ROW_EVEN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end

                ROW_EVEN: begin
                    if (w_xfer) begin
                        if (w_last_col) begin
                            r_col   <= '0;
                            r_state <= ROW_ODD;
                        end else begin
                            r_col <= r_col + DIM_ONE;
                        end
                    end
                end

                ROW_ODD: begin
                    if (w_xfer) begin
                        if (!r_col[0] && w_last_col) begin
                            // Trailing element of an odd-width row has no partner.
                            r_col      <= '0;
                            r_row_pair <= r_row_pair + DIM_ONE;
                            r_state    <= w_row_done_state;
                        end else if (!r_col[0]) begin
                            r_hold <= in_data;
                            r_col  <= r_col + DIM_ONE;
                        end else begin
                            r_cur         <= in_data;
                            r_pool_enable <= 1'b1;
                            r_pool_data   <= w_rd_data;
                            r_emit_idx    <= '0;
                            r_state       <= EMIT;
                        end
                    end
                end

                EMIT: begin
                    r_emit_idx <= r_emit_idx + 2'd1;
                    case (r_emit_idx)
                        2'd0:    r_pool_data <= w_rd_data;
                        2'd1:    r_pool_data <= r_hold;
                        2'd2:    r_pool_data <= r_cur;
                        default: r_pool_data <= '0;
                    endcase
                    if (r_emit_idx == EMIT_LAST) begin
                        r_pool_enable <= 1'b0;
                        r_pool_data   <= '0;
                        if ((r_col + DIM_ONE) < r_width) begin
                            r_col   <= r_col + DIM_ONE;
                            r_state <= ROW_ODD;
                        end else begin
                            r_col      <= '0;
                            r_row_pair <= r_row_pair + DIM_ONE;
                            r_state    <= w_row_done_state;
                        end
                    end
                end

                SKIP_ROW: begin
                    if (w_xfer) begin
                        if (w_last_col) begin
                            r_col   <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_col <= r_col + DIM_ONE;
                        end
                    end
                end

                DRAIN: begin
                    // Look-ahead on the count so done follows the final result by one cycle.
                    if (w_cnt_next == r_total) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef POOL_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if ((r_state == IDLE) && cfg_start) begin
            r_stall_cnt <= '0;
        end else if (r_busy && in_valid && !in_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_stall_cycles = r_stall_cnt;
`else
    assign perf_stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pool_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : tb_pool_window_scheduler
// Description: Directed bench for pool_window_scheduler with a 2x2 max-pool model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_pool_window_scheduler;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_start = 1'b0;
    logic [6:0]        cfg_width = '0;
    logic [6:0]        cfg_height = '0;
    logic [7:0]        in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              pool_clear;
    logic              pool_enable;
    logic signed [7:0] pool_data;
    logic              pool_data_valid;
    logic              pool_result_valid = 1'b0;
    logic              busy;
    logic              done;
    logic [31:0]       perf_stall_cycles;

    int n_checks = 0;
    int n_fail = 0;

    int n_emit, n_emit_ready, n_res, n_done, n_clear, n_stall;
    int cyc = 0;
    int last_res_cyc, done_cyc;
    logic signed [7:0] out_log [0:63];
    logic signed [7:0] stim [0:63];

    int m_idx = 0;
    logic signed [7:0] m_max = '0;
    logic signed [7:0] m_result = '0;

    int E1 [16] = '{1, 2, 5, 6, 3, 4, 7, 8, 9, 10, 13, 14, 11, 12, 15, 16};
    int E2 [4]  = '{-5, -3, -8, -1};
    int E3 [8]  = '{1, 2, 6, 7, 3, 4, 8, 9};

    pool_window_scheduler dut (
        .clock             (clock),
        .reset             (reset),
        .cfg_start         (cfg_start),
        .cfg_width         (cfg_width),
        .cfg_height        (cfg_height),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .pool_clear        (pool_clear),
        .pool_enable       (pool_enable),
        .pool_data         (pool_data),
        .pool_data_valid   (pool_data_valid),
        .pool_result_valid (pool_result_valid),
        .busy              (busy),
        .done              (done),
        .perf_stall_cycles (perf_stall_cycles)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Registered 2x2 max-pool unit; pool_clear is ORed into its reset.
    always @(posedge clock) begin
        if (reset || pool_clear) begin
            m_idx             <= 0;
            pool_result_valid <= 1'b0;
        end else begin
            pool_result_valid <= 1'b0;
            if (pool_enable) begin
                if (m_idx == 0 || pool_data > m_max) m_max <= pool_data;
                if (m_idx == 3) begin
                    pool_result_valid <= 1'b1;
                    m_result          <= (pool_data > m_max) ? pool_data : m_max;
                    m_idx             <= 0;
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    always begin
        @(negedge clock);
        #2;
        if (pool_enable) begin
            if (n_emit < 64) out_log[n_emit] = pool_data;
            n_emit++;
            if (in_ready || !pool_data_valid) n_emit_ready++;
        end
        if (pool_result_valid) begin
            n_res++;
            last_res_cyc = cyc;
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (pool_clear) n_clear++;
        if (busy && in_valid && !in_ready) n_stall++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        n_emit = 0; n_emit_ready = 0; n_res = 0; n_done = 0; n_clear = 0; n_stall = 0;
        last_res_cyc = -100; done_cyc = -1;
        for (int i = 0; i < 64; i++) out_log[i] = '0;
    endtask

    task automatic start_map(input int w, input int h);
        @(negedge clock); #1;
        cfg_width  = 7'(w);
        cfg_height = 7'(h);
        cfg_start  = 1'b1;
        @(negedge clock); #1;
        cfg_start  = 1'b0;
    endtask

    task automatic feed(input int n, input bit toggle, input int abort_at, input int mid_start_at);
        int idx, guard;
        bit ph, fired, aborted;
        idx = 0; guard = 0; ph = 1'b0; fired = 1'b0; aborted = 1'b0;
        while (idx < n && guard < 600) begin
            @(negedge clock); #1;
            guard++;
            cfg_start = 1'b0;
            if (abort_at > 0 && n_emit >= abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (mid_start_at >= 0 && idx == mid_start_at && !fired) begin
                cfg_start  = 1'b1;
                cfg_width  = 7'd2;
                cfg_height = 7'd2;
                fired      = 1'b1;
            end
            ph       = ~ph;
            in_valid = toggle ? ph : 1'b1;
            in_data  = stim[idx];
            if (in_valid && in_ready) idx++;
        end
        if (aborted) begin
            in_valid = 1'b0;
        end else begin
            chk("feed_complete", idx, n);
            @(negedge clock); #1;
            cfg_start = 1'b0;
            in_valid  = 1'b0;
        end
    endtask

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clock); #3;
            if (n_done > 0) break;
        end
        repeat (3) @(negedge clock);
        #3;
    endtask

    initial begin
        clear_logs();
        repeat (3) @(negedge clock);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_pool_enable", pool_enable, 0);
        chk("rst_pool_data_valid", pool_data_valid, 0);
        chk("rst_pool_data", pool_data, 0);
        chk("rst_done", done, 0);
        chk("rst_pool_clear", pool_clear, 0);
        chk("rst_perf", perf_stall_cycles, 0);
        reset = 1'b0;

        // 4x4 map, continuous input
        for (int i = 0; i < 16; i++) stim[i] = 8'(i + 1);
        clear_logs();
        start_map(4, 4);
        feed(16, 1'b0, 0, -1);
        wait_done(100);
        chk("s1_emit_count", n_emit, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("s1_elem%0d", i), out_log[i], E1[i]);
        chk("s1_results", n_res, 4);
        chk("s1_done_count", n_done, 1);
        chk("s1_done_latency", done_cyc - last_res_cyc, 1);
        chk("s1_clear_pulses", n_clear, 1);
        chk("s1_emit_in_ready", n_emit_ready, 0);
        chk("s1_busy_after", busy, 0);

        // 2x2 signed map
        stim[0] = -8'sd5; stim[1] = -8'sd3; stim[2] = -8'sd8; stim[3] = -8'sd1;
        clear_logs();
        start_map(2, 2);
        feed(4, 1'b0, 0, -1);
        wait_done(100);
        chk("s2_emit_count", n_emit, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("s2_elem%0d", i), out_log[i], E2[i]);
        chk("s2_pool_result", m_result, -1);
        chk("s2_done_count", n_done, 1);

        // 5x3 map: odd width and odd height
        for (int i = 0; i < 15; i++) stim[i] = 8'(i + 1);
        clear_logs();
        start_map(5, 3);
        feed(15, 1'b0, 0, -1);
        wait_done(100);
        chk("s3_emit_count", n_emit, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("s3_elem%0d", i), out_log[i], E3[i]);
        chk("s3_results", n_res, 2);
        chk("s3_done_count", n_done, 1);
        chk("s3_in_ready_idle", in_ready, 0);

        // 4x4 map with in_valid toggling
        for (int i = 0; i < 16; i++) stim[i] = 8'(i + 1);
        clear_logs();
        start_map(4, 4);
        feed(16, 1'b1, 0, -1);
        wait_done(100);
        chk("s4_emit_count", n_emit, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("s4_elem%0d", i), out_log[i], E1[i]);
        chk("s4_emit_in_ready", n_emit_ready, 0);
        chk("s4_done_count", n_done, 1);

        // Reset during the second window
        clear_logs();
        start_map(4, 4);
        feed(16, 1'b0, 5, -1);
        reset = 1'b1;
        @(negedge clock); #2;
        chk("s5_busy", busy, 0);
        chk("s5_pool_enable", pool_enable, 0);
        chk("s5_pool_data", pool_data, 0);
        chk("s5_in_ready", in_ready, 0);
        chk("s5_done", done, 0);
        chk("s5_pool_clear", pool_clear, 0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        #3;
        chk("s5_no_done", n_done, 0);
        clear_logs();
        start_map(4, 4);
        feed(16, 1'b0, 0, -1);
        wait_done(100);
        chk("s5_emit_count", n_emit, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("s5_elem%0d", i), out_log[i], E1[i]);
        chk("s5_clear_pulses", n_clear, 1);
        chk("s5_done_count", n_done, 1);

        // cfg_start mid-map is ignored
        clear_logs();
        start_map(4, 4);
        feed(16, 1'b0, 0, 6);
        chk("s6_busy_mid", busy, 1);
        wait_done(100);
        chk("s6_emit_count", n_emit, 16);
        for (int i = 0; i < 16; i++) chk($sformatf("s6_elem%0d", i), out_log[i], E1[i]);
        chk("s6_clear_pulses", n_clear, 1);
        chk("s6_done_count", n_done, 1);
`ifdef POOL_SCHED_PERF_EN
        chk("s6_perf_stall", perf_stall_cycles, n_stall);
`else
        chk("s6_perf_stall", perf_stall_cycles, 0);
`endif

        // Illegal width completes immediately with no windows
        clear_logs();
        start_map(1, 4);
        wait_done(20);
        chk("s7_done_count", n_done, 1);
        chk("s7_emit_count", n_emit, 0);
        chk("s7_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
